// File: rtl/bxu_io_sequencer.sv
// BXU program sequencer: fetches 16-bit {operand, opcode} words from a combinational ROM
// and moves bytes between the UART RX/TX handshakes and the data register. Optional JMP: BXU_SEQ_JMP_EN.
module bxu_io_sequencer #(
  parameter int DATA_BITWIDTH = 16,
  parameter int ADDR_BITWIDTH = 16,
  parameter logic [ADDR_BITWIDTH-1:0] PC_LAST = {ADDR_BITWIDTH{1'b1}}
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [ADDR_BITWIDTH-1:0] addr_rd,
  input  logic [DATA_BITWIDTH-1:0] data_rd,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     busy_io
);

  localparam int OPND_W = DATA_BITWIDTH - 4;

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_IN    = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  localparam logic [3:0] OP_IN  = 4'b1011;
  localparam logic [3:0] OP_OUT = 4'b0011;
  localparam logic [3:0] OP_JMP = 4'b0001;

  logic [1:0]               state;
  logic [ADDR_BITWIDTH-1:0] pc;
  logic [DATA_BITWIDTH-1:0] ir;
  logic [7:0]               d;

  logic [3:0]        opcode;
  logic [OPND_W-1:0] operand;

  assign opcode  = ir[3:0];
  assign operand = ir[DATA_BITWIDTH-1:4];
  assign addr_rd = pc;
  assign busy_io = (state == S_IN) || (state == S_OUT);

  function automatic logic [ADDR_BITWIDTH-1:0] next_pc(input logic [ADDR_BITWIDTH-1:0] cur);
    return (cur == PC_LAST) ? '0 : cur + ADDR_BITWIDTH'(1);
  endfunction

  // operand[9] selects the data register over the 8-bit immediate
  function automatic logic [7:0] out_byte(input logic sel_d, input logic [7:0] imm,
                                          input logic [7:0] dreg);
    return sel_d ? dreg : imm;
  endfunction

`ifdef BXU_SEQ_JMP_EN
  logic [ADDR_BITWIDTH-1:0] jmp_target;
  assign jmp_target = ADDR_BITWIDTH'(operand);
`else
  logic unused_operand_bits;
  assign unused_operand_bits = ^{operand[OPND_W-1:10], operand[8]};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      pc       <= '0;
      ir       <= '0;
      d        <= 8'h00;
      rx_ready <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      case (state)
        S_FETCH: begin
          ir    <= data_rd;
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (opcode == OP_IN) begin
            rx_ready <= 1'b1;
            state    <= S_IN;
          end else if (opcode == OP_OUT) begin
            tx_data  <= out_byte(operand[9], operand[7:0], d);
            tx_valid <= 1'b1;
            state    <= S_OUT;
          end
`ifdef BXU_SEQ_JMP_EN
          else if (opcode == OP_JMP) begin
            pc    <= jmp_target;
            state <= S_FETCH;
          end
`endif
          else begin
            pc    <= next_pc(pc);
            state <= S_FETCH;
          end
        end
        // handshakes complete only once the state has raised its own ready/valid
        S_IN: begin
          if (rx_valid && rx_ready) begin
            d        <= rx_data;
            rx_ready <= 1'b0;
            pc       <= next_pc(pc);
            state    <= S_FETCH;
          end
        end
        S_OUT: begin
          if (tx_valid && tx_ready) begin
            tx_valid <= 1'b0;
            pc       <= next_pc(pc);
            state    <= S_FETCH;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_bxu_io_sequencer.sv
// Bench for bxu_io_sequencer: echo-program instance (PC_LAST=3) plus a free-form ROM instance.
module tb_bxu_io_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // instance A: echo program
  logic [15:0] addr_rd_a, data_rd_a;
  logic [7:0]  rx_data_a, tx_data_a;
  logic        rx_valid_a, rx_ready_a, tx_valid_a, tx_ready_a, busy_a;

  // instance B: programmable ROM, full 16-bit pc range
  logic [15:0] addr_rd_b, data_rd_b;
  logic [7:0]  rx_data_b, tx_data_b;
  logic        rx_valid_b, rx_ready_b, tx_valid_b, tx_ready_b, busy_b;
  logic [15:0] rom_b [8];

  bxu_io_sequencer #(.DATA_BITWIDTH(16), .ADDR_BITWIDTH(16), .PC_LAST(16'd3)) dut_a (
    .clk(clk), .rst(rst), .addr_rd(addr_rd_a), .data_rd(data_rd_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .busy_io(busy_a));

  bxu_io_sequencer #(.DATA_BITWIDTH(16), .ADDR_BITWIDTH(16), .PC_LAST(16'hFFFF)) dut_b (
    .clk(clk), .rst(rst), .addr_rd(addr_rd_b), .data_rd(data_rd_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .busy_io(busy_b));

  // echo: IN d; OUT d; OUT #','; OUT #' '
  always_comb begin
    case (addr_rd_a)
      16'd0:   data_rd_a = 16'h000B;
      16'd1:   data_rd_a = 16'h2003;
      16'd2:   data_rd_a = 16'h02C3;
      16'd3:   data_rd_a = 16'h0203;
      default: data_rd_a = 16'h0000;
    endcase
  end

  always_comb begin
    data_rd_b = 16'h0000;
    if (addr_rd_b < 16'd8) data_rd_b = rom_b[addr_rd_b[2:0]];
  end

  // transfer logs: a transfer happens on the next rising edge when valid&ready hold now
  logic [7:0] tx_log_a[$], rx_log_a[$], tx_log_b[$], rx_log_b[$];
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_valid_a && tx_ready_a) tx_log_a.push_back(tx_data_a);
      if (rx_valid_a && rx_ready_a) rx_log_a.push_back(rx_data_a);
      if (tx_valid_b && tx_ready_b) tx_log_b.push_back(tx_data_b);
      if (rx_valid_b && rx_ready_b) rx_log_b.push_back(rx_data_b);
    end
  end

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_valid_a = 1'b0; rx_data_a = 8'h00; tx_ready_a = 1'b0;
    rx_valid_b = 1'b0; rx_data_b = 8'h00; tx_ready_b = 1'b0;
    run(2);
    tx_log_a.delete(); rx_log_a.delete(); tx_log_b.delete(); rx_log_b.delete();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_valid_a = 1'b1; rx_data_a = 8'hA5; tx_ready_a = 1'b1;
    rx_valid_b = 1'b0; rx_data_b = 8'h00; tx_ready_b = 1'b0;
    run(2);
    checks++; if (addr_rd_a !== 16'd0) begin errors++; $display("FAIL reset_pc got %h expected 0000", addr_rd_a); end
    checks++; if (tx_valid_a !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b expected 0", tx_valid_a); end
    checks++; if (rx_ready_a !== 1'b0) begin errors++; $display("FAIL reset_rx_ready got %b expected 0", rx_ready_a); end
    checks++; if (tx_data_a !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h expected 00", tx_data_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy_a); end
    checks++; if (dut_a.d !== 8'h00) begin errors++; $display("FAIL reset_d got %h expected 00", dut_a.d); end
    rx_valid_a = 1'b0;
    tx_log_a.delete(); rx_log_a.delete();
    rst = 1'b0;
    run(2);
    checks++; if (rx_ready_a !== 1'b1 || busy_a !== 1'b1) begin
      errors++; $display("FAIL first_in rx_ready/busy got %b/%b expected 1/1", rx_ready_a, busy_a);
    end
  endtask

  task automatic test_echo_hold();
    logic [7:0] exp [3];
    exp[0] = 8'h41; exp[1] = 8'h2C; exp[2] = 8'h20;
    do_reset();
    rx_valid_a = 1'b1; rx_data_a = 8'h41; tx_ready_a = 1'b1;
    run(12);
    rx_valid_a = 1'b0;
    checks++; if (rx_log_a.size() !== 1) begin errors++; $display("FAIL echo_rx_count got %0d expected 1", rx_log_a.size()); end
    checks++; if (addr_rd_a !== 16'd0) begin errors++; $display("FAIL echo_pc_wrap got %h expected 0000", addr_rd_a); end
    checks++; if (tx_log_a.size() !== 3) begin
      errors++; $display("FAIL echo_tx_count got %0d expected 3", tx_log_a.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (tx_log_a[i] !== exp[i]) begin errors++; $display("FAIL echo_tx[%0d] got %h expected %h", i, tx_log_a[i], exp[i]); end
      end
    end
  endtask

  task automatic test_tx_stall();
    logic [7:0] exp [3];
    exp[0] = 8'h41; exp[1] = 8'h2C; exp[2] = 8'h20;
    do_reset();
    rx_valid_a = 1'b1; rx_data_a = 8'h41; tx_ready_a = 1'b0;
    run(3);
    rx_valid_a = 1'b0;
    run(2);
    for (int i = 0; i < 10; i++) begin
      checks++; if (tx_valid_a !== 1'b1 || tx_data_a !== 8'h41 || addr_rd_a !== 16'd1) begin
        errors++; $display("FAIL stall_hold[%0d] got v=%b d=%h pc=%h expected v=1 d=41 pc=0001", i, tx_valid_a, tx_data_a, addr_rd_a);
      end
      run(1);
    end
    checks++; if (tx_log_a.size() !== 0) begin errors++; $display("FAIL stall_no_emit got %0d expected 0", tx_log_a.size()); end
    tx_ready_a = 1'b1;
    run(1);
    checks++; if (tx_valid_a !== 1'b0 || addr_rd_a !== 16'd2 || tx_log_a.size() !== 1) begin
      errors++; $display("FAIL stall_release got v=%b pc=%h n=%0d expected v=0 pc=0002 n=1", tx_valid_a, addr_rd_a, tx_log_a.size());
    end
    run(6);
    checks++; if (tx_log_a.size() !== 3) begin
      errors++; $display("FAIL stall_tx_count got %0d expected 3", tx_log_a.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (tx_log_a[i] !== exp[i]) begin errors++; $display("FAIL stall_tx[%0d] got %h expected %h", i, tx_log_a[i], exp[i]); end
      end
    end
  endtask

  task automatic test_rx_idle();
    logic [7:0] exp [3];
    exp[0] = 8'h5A; exp[1] = 8'h2C; exp[2] = 8'h20;
    do_reset();
    tx_ready_a = 1'b1;
    run(20);
    checks++; if (tx_log_a.size() !== 0 || tx_valid_a !== 1'b0) begin
      errors++; $display("FAIL idle_no_tx got n=%0d v=%b expected n=0 v=0", tx_log_a.size(), tx_valid_a);
    end
    checks++; if (rx_ready_a !== 1'b1 || addr_rd_a !== 16'd0) begin
      errors++; $display("FAIL idle_wait got rdy=%b pc=%h expected rdy=1 pc=0000", rx_ready_a, addr_rd_a);
    end
    rx_valid_a = 1'b1; rx_data_a = 8'h5A;
    run(1);
    rx_valid_a = 1'b0;
    run(9);
    checks++; if (rx_log_a.size() !== 1) begin errors++; $display("FAIL idle_rx_count got %0d expected 1", rx_log_a.size()); end
    checks++; if (tx_log_a.size() !== 3) begin
      errors++; $display("FAIL idle_tx_count got %0d expected 3", tx_log_a.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (tx_log_a[i] !== exp[i]) begin errors++; $display("FAIL idle_tx[%0d] got %h expected %h", i, tx_log_a[i], exp[i]); end
      end
    end
  endtask

  task automatic test_reset_in_out();
    do_reset();
    rx_valid_a = 1'b1; rx_data_a = 8'($urandom_range(1, 255)); tx_ready_a = 1'b0;
    run(5);
    rx_valid_a = 1'b0;
    checks++; if (tx_valid_a !== 1'b1 || busy_a !== 1'b1) begin
      errors++; $display("FAIL rst_out_pre got v=%b busy=%b expected 1/1", tx_valid_a, busy_a);
    end
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    checks++; if (tx_valid_a !== 1'b0 || addr_rd_a !== 16'd0 || dut_a.d !== 8'h00 || rx_ready_a !== 1'b0) begin
      errors++; $display("FAIL rst_out_post got v=%b pc=%h d=%h rdy=%b expected v=0 pc=0000 d=00 rdy=0",
                         tx_valid_a, addr_rd_a, dut_a.d, rx_ready_a);
    end
    tx_ready_a = 1'b1;
    run(2);
    checks++; if (rx_ready_a !== 1'b1 || tx_log_a.size() !== 0) begin
      errors++; $display("FAIL rst_restart_in got rdy=%b n=%0d expected rdy=1 n=0", rx_ready_a, tx_log_a.size());
    end
  endtask

  task automatic test_random_echo();
    localparam int N = 20;
    logic [7:0] bytes [N];
    logic [7:0] model [$];
    logic       stalled;
    logic [7:0] held;
    int         cyc;
    for (int i = 0; i < N; i++) begin
      bytes[i] = 8'($urandom);
      model.push_back(bytes[i]); model.push_back(8'h2C); model.push_back(8'h20);
    end
    do_reset();
    cyc = 0;
    while (!(rx_log_a.size() == N && tx_log_a.size() == 3 * N) && cyc < 4000) begin
      if (rx_log_a.size() < N) begin
        rx_data_a  = bytes[rx_log_a.size()];
        rx_valid_a = ($urandom_range(0, 2) != 0);
      end else begin
        rx_valid_a = 1'b0;
      end
      tx_ready_a = ($urandom_range(0, 3) != 0);
      stalled = tx_valid_a && !tx_ready_a;
      held    = tx_data_a;
      run(1);
      cyc++;
      if (stalled) begin
        checks++; if (tx_valid_a !== 1'b1 || tx_data_a !== held) begin
          errors++; $display("FAIL rand_stable got v=%b d=%h expected v=1 d=%h", tx_valid_a, tx_data_a, held);
        end
      end
    end
    rx_valid_a = 1'b0;
    checks++; if (cyc >= 4000) begin
      errors++; $display("FAIL rand_timeout got rx=%0d tx=%0d expected rx=%0d tx=%0d", rx_log_a.size(), tx_log_a.size(), N, 3 * N);
    end else begin
      for (int i = 0; i < N; i++) begin
        checks++; if (rx_log_a[i] !== bytes[i]) begin errors++; $display("FAIL rand_rx[%0d] got %h expected %h", i, rx_log_a[i], bytes[i]); end
      end
      for (int i = 0; i < 3 * N; i++) begin
        checks++; if (tx_log_a[i] !== model[i]) begin errors++; $display("FAIL rand_tx[%0d] got %h expected %h", i, tx_log_a[i], model[i]); end
      end
      checks++; if (addr_rd_a !== 16'd0) begin errors++; $display("FAIL rand_pc_end got %h expected 0000", addr_rd_a); end
    end
  endtask

  task automatic test_jmp();
    logic [15:0] exp_pc;
`ifdef BXU_SEQ_JMP_EN
    exp_pc = 16'd0;
`else
    exp_pc = 16'd4;
`endif
    for (int i = 0; i < 8; i++) rom_b[i] = 16'h0000;
    rom_b[0] = 16'h000B; rom_b[1] = 16'h0000; rom_b[2] = 16'h2003; rom_b[3] = 16'h0001;
    do_reset();
    rx_valid_b = 1'b1; rx_data_b = 8'h33; tx_ready_b = 1'b1;
    run(3);
    rx_valid_b = 1'b0;
    run(7);
    checks++; if (tx_log_b.size() !== 1) begin
      errors++; $display("FAIL jmp_tx_count got %0d expected 1", tx_log_b.size());
    end else begin
      checks++; if (tx_log_b[0] !== 8'h33) begin errors++; $display("FAIL jmp_tx got %h expected 33", tx_log_b[0]); end
    end
    checks++; if (addr_rd_b !== exp_pc) begin errors++; $display("FAIL jmp_pc got %h expected %h", addr_rd_b, exp_pc); end
  endtask

  task automatic test_operand_bits();
    logic [7:0] r;
    r = 8'($urandom_range(0, 254));
    for (int i = 0; i < 8; i++) rom_b[i] = 16'h0000;
    rom_b[0] = 16'h000B; rom_b[1] = 16'h2FF3; rom_b[2] = 16'h1FF3;
    do_reset();
    rx_valid_b = 1'b1; rx_data_b = r; tx_ready_b = 1'b1;
    run(3);
    rx_valid_b = 1'b0;
    run(6);
    checks++; if (tx_log_b.size() !== 2) begin
      errors++; $display("FAIL opnd_tx_count got %0d expected 2", tx_log_b.size());
    end else begin
      checks++; if (tx_log_b[0] !== r) begin errors++; $display("FAIL opnd_bit9_set got %h expected %h", tx_log_b[0], r); end
      checks++; if (tx_log_b[1] !== 8'hFF) begin errors++; $display("FAIL opnd_bit9_clr got %h expected ff", tx_log_b[1]); end
    end
    checks++; if (addr_rd_b !== 16'd3) begin errors++; $display("FAIL opnd_pc got %h expected 0003", addr_rd_b); end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rom_b[i] = 16'h0000;
    test_reset();
    test_echo_hold();
    test_tx_stall();
    test_rx_idle();
    test_reset_in_out();
    test_random_echo();
    test_jmp();
    test_operand_bits();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
